// File: rtl/clk_strobe_pkg.sv
// Shared types for the clock-strobe generator: FSM state encoding and the
// lock-loss counter width with its saturating increment.
package clk_strobe_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } state_e;

  localparam int LOSS_CNT_W = 8;

  function automatic logic [LOSS_CNT_W-1:0] sat_inc(input logic [LOSS_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/clk_strobe_ch.sv
// One strobe channel: free-running divider counter with a divisor latched at
// RUN entry and at every wrap, driving a registered one-cycle strobe.
module clk_strobe_ch
  import clk_strobe_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_i,
  input  logic             run_next_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] div_i,
  input  logic [CNT_W-1:0] phase_i,
  output logic             strobe_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_eff_q, div_eff_d;
  logic             strobe_q, strobe_d;

  always_comb begin
    cnt_d     = cnt_q;
    div_eff_d = div_eff_q;
    strobe_d  = 1'b0;
    if (!run_next_i) begin
      cnt_d = '0;
    end else if (!run_i) begin
      // Entering RUN: an out-of-range start phase falls back to 0.
      div_eff_d = div_i;
      cnt_d     = (phase_i < div_i) ? phase_i : '0;
    end else if (div_eff_q == '0) begin
      cnt_d     = '0;
      div_eff_d = div_i;
    end else if (en_i) begin
      if (cnt_q == div_eff_q - 1'b1) begin
        cnt_d     = '0;
        strobe_d  = 1'b1;
        div_eff_d = div_i;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      div_eff_q <= '0;
      strobe_q  <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_eff_q <= div_eff_d;
      strobe_q  <= strobe_d;
    end
  end

  assign strobe_o = strobe_q;

endmodule

// File: rtl/clk_strobe_gen.sv
// PLL-lock sequencer plus NUM_CH programmable clock-enable strobes.
// Define CLK_STROBE_PHASE_EN to add the per-channel phase_i start-phase port.
module clk_strobe_gen
  import clk_strobe_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 8,
  parameter int SETTLE_CYC  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pll_locked_i,
  input  logic                    en_i,
  input  logic [NUM_CH*CNT_W-1:0] div_i,
`ifdef CLK_STROBE_PHASE_EN
  input  logic [NUM_CH*CNT_W-1:0] phase_i,
`endif
  output logic [NUM_CH-1:0]       strobe_o,
  output logic                    ready_o,
  output logic                    rst_sync_n_o,
  output logic [LOSS_CNT_W-1:0]   lock_loss_cnt_o
);

  localparam int SET_W = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC + 1);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYC - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_sync;
  state_e                 state_q, state_d;
  logic [SET_W-1:0]       settle_q, settle_d;
  logic [LOSS_CNT_W-1:0]  loss_q, loss_d;
  logic                   ready_q;
  logic                   run_cur, run_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked_i};
    end
  end

  assign lock_sync = sync_q[SYNC_STAGES-1];

  // The WAIT_LOCK cycle that first sees lock counts toward the settle window,
  // so RUN starts after exactly SETTLE_CYC cycles of synced lock.
  always_comb begin
    state_d  = state_q;
    settle_d = '0;
    loss_d   = loss_q;
    case (state_q)
      WAIT_LOCK: begin
        if (lock_sync) state_d = (SETTLE_CYC <= 1) ? RUN : SETTLE;
      end
      SETTLE: begin
        if (!lock_sync) begin
          state_d = WAIT_LOCK;
        end else begin
          settle_d = settle_q + 1'b1;
          if (settle_d == SETTLE_LAST) begin
            state_d  = RUN;
            settle_d = '0;
          end
        end
      end
      RUN: begin
        if (!lock_sync) begin
          state_d = WAIT_LOCK;
          loss_d  = sat_inc(loss_q);
        end
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= WAIT_LOCK;
      settle_q <= '0;
      loss_q   <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      loss_q   <= loss_d;
      ready_q  <= (state_d == RUN);
    end
  end

  assign run_cur  = (state_q == RUN);
  assign run_next = (state_d == RUN);

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [CNT_W-1:0] ch_phase;
`ifdef CLK_STROBE_PHASE_EN
      assign ch_phase = phase_i[gi*CNT_W +: CNT_W];
`else
      assign ch_phase = '0;
`endif
      clk_strobe_ch #(
        .CNT_W(CNT_W)
      ) u_ch (
        .clk       (clk),
        .rst_n     (rst_n),
        .run_i     (run_cur),
        .run_next_i(run_next),
        .en_i      (en_i),
        .div_i     (div_i[gi*CNT_W +: CNT_W]),
        .phase_i   (ch_phase),
        .strobe_o  (strobe_o[gi])
      );
    end
  endgenerate

  assign ready_o         = ready_q;
  assign rst_sync_n_o    = ready_q;
  assign lock_loss_cnt_o = loss_q;

endmodule

// File: tb/tb_clk_strobe_gen.sv
// Self-checking bench for clk_strobe_gen: lock sequencing, divider rates,
// divisor changes, enable freeze, lock-loss saturation and (optionally) phase.
module tb_clk_strobe_gen;
  localparam int NUM_CH      = 4;
  localparam int CNT_W       = 8;
  localparam int SETTLE_CYC  = 16;
  localparam int SYNC_STAGES = 2;
  localparam int RUN_LAT     = SYNC_STAGES + SETTLE_CYC;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    pll_locked;
  logic                    en;
  logic [NUM_CH*CNT_W-1:0] div;
`ifdef CLK_STROBE_PHASE_EN
  logic [NUM_CH*CNT_W-1:0] phase;
`endif
  logic [NUM_CH-1:0]       strobe;
  logic                    ready;
  logic                    rst_sync_n;
  logic [7:0]              loss_cnt;

  int checks   = 0;
  int failures = 0;
  int model_div[NUM_CH];
  int model_ph[NUM_CH];
  int first_idx[NUM_CH];

  always #5 clk = ~clk;

  clk_strobe_gen #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .SETTLE_CYC(SETTLE_CYC), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pll_locked_i   (pll_locked),
    .en_i           (en),
    .div_i          (div),
`ifdef CLK_STROBE_PHASE_EN
    .phase_i        (phase),
`endif
    .strobe_o       (strobe),
    .ready_o        (ready),
    .rst_sync_n_o   (rst_sync_n),
    .lock_loss_cnt_o(loss_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int d0, input int d1, input int d2, input int d3,
                         input int p0, input int p1, input int p2, input int p3);
    model_div[0] = d0; model_div[1] = d1; model_div[2] = d2; model_div[3] = d3;
    model_ph[0]  = p0; model_ph[1]  = p1; model_ph[2]  = p2; model_ph[3]  = p3;
`ifndef CLK_STROBE_PHASE_EN
    for (int c = 0; c < NUM_CH; c++) model_ph[c] = 0;
`endif
    for (int c = 0; c < NUM_CH; c++) begin
      div[c*CNT_W +: CNT_W] = CNT_W'(model_div[c]);
`ifdef CLK_STROBE_PHASE_EN
      phase[c*CNT_W +: CNT_W] = CNT_W'(model_ph[c]);
`endif
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; pll_locked = 1'b0; en = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Raise lock and wait (bounded) for RUN; exact latency is checked.
  task automatic bring_up(input string tag, output bit ok);
    int n = 0;
    pll_locked = 1'b1;
    while (ready !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    checks++;
    ok = (ready === 1'b1);
    if (ready !== 1'b1 || rst_sync_n !== 1'b1 || n != RUN_LAT) begin
      failures++;
      $display("FAIL %s bring_up: ready=%b rst_sync_n=%b after %0d cycles, required 1/1 after %0d",
               tag, ready, rst_sync_n, n, RUN_LAT);
    end
  endtask

  // Reference: a strobe follows the enabled cycle in which (enabled RUN
  // cycles so far + start phase) is a multiple of the divisor.
  task automatic run_and_check(input string tag, input int len, input int en_pct);
    int n[NUM_CH];
    int p_eff;
    logic [NUM_CH-1:0] exp_s = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      n[c] = 0;
      first_idx[c] = -1;
    end
    for (int idx = 0; idx < len; idx++) begin
      checks++;
      if (strobe !== exp_s) begin
        failures++;
        $display("FAIL %s strobe idx=%0d: got %b required %b", tag, idx, strobe, exp_s);
      end
      for (int c = 0; c < NUM_CH; c++)
        if (strobe[c] === 1'b1 && first_idx[c] < 0) first_idx[c] = idx;
      en = ($urandom_range(99) < en_pct);
      for (int c = 0; c < NUM_CH; c++) begin
        p_eff = (model_ph[c] < model_div[c]) ? model_ph[c] : 0;
        if (en) n[c]++;
        exp_s[c] = en && (model_div[c] != 0) &&
                   (((n[c] + p_eff) % ((model_div[c] != 0) ? model_div[c] : 1)) == 0);
      end
      tick();
    end
  endtask

  task automatic test_reset();
    bit ok;
    rst_n = 1'b0; pll_locked = 1'b0; en = 1'b0;
    set_cfg(1, 1, 1, 1, 0, 0, 0, 0);
    tick();
    checks++;
    if ({strobe, ready, rst_sync_n, loss_cnt} !== 15'b0) begin
      failures++;
      $display("FAIL reset_state: strobe=%b ready=%b rst_sync_n=%b loss=%0d required all 0",
               strobe, ready, rst_sync_n, loss_cnt);
    end
    rst_n = 1'b1;
    en = 1'b1;
    tick();
    bring_up("async_reset", ok);
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({strobe, ready, rst_sync_n} !== 6'b0) begin
      failures++;
      $display("FAIL async_reset: strobe=%b ready=%b rst_sync_n=%b required all 0",
               strobe, ready, rst_sync_n);
    end
    tick();
    rst_n = 1'b1;
    pll_locked = 1'b0;
    tick();
  endtask

  task automatic test_lock_seq();
    int n = 0;
    do_reset();
    repeat (10) tick();
    pll_locked = 1'b1;
    while (ready !== 1'b1 && n < 60) begin
      checks++;
      if (rst_sync_n !== 1'b0) begin
        failures++;
        $display("FAIL lock_seq_early: rst_sync_n=%b at cycle %0d required 0", rst_sync_n, n);
      end
      tick();
      n++;
    end
    checks++;
    if (n != RUN_LAT || rst_sync_n !== 1'b1) begin
      failures++;
      $display("FAIL lock_seq: ready after %0d cycles rst_sync_n=%b, required %0d and 1",
               n, rst_sync_n, RUN_LAT);
    end
  endtask

  task automatic test_divider_rates();
    bit ok;
    int want[NUM_CH] = '{1, 2, 4, 8};
    do_reset();
    set_cfg(1, 2, 4, 8, 0, 0, 0, 0);
    en = 1'b1;
    bring_up("rates", ok);
    if (ok) begin
      run_and_check("rates", 40, 100);
      for (int c = 0; c < NUM_CH; c++) begin
        checks++;
        if (first_idx[c] != want[c]) begin
          failures++;
          $display("FAIL rates_first ch%0d: first strobe idx %0d required %0d", c, first_idx[c], want[c]);
        end
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    for (int r = 0; r < 4; r++) begin
      do_reset();
      set_cfg($urandom_range(12), $urandom_range(12), $urandom_range(12), $urandom_range(12),
              $urandom_range(15), $urandom_range(15), $urandom_range(15), $urandom_range(15));
      en = 1'b1;
      bring_up("random", ok);
      if (ok) run_and_check("random", 150, 70);
    end
  endtask

  task automatic test_div_change();
    bit ok;
    logic [NUM_CH-1:0] exp_s;
    do_reset();
    set_cfg(8, 0, 0, 0, 0, 0, 0, 0);
    en = 1'b1;
    bring_up("div_change", ok);
    for (int idx = 0; idx < 28 && ok; idx++) begin
      exp_s = {3'b000, (idx == 8 || idx == 16 || idx == 19 || idx == 22 || idx == 25)};
      checks++;
      if (strobe !== exp_s) begin
        failures++;
        $display("FAIL div_change idx=%0d: got %b required %b", idx, strobe, exp_s);
      end
      if (idx == 10) div[0 +: CNT_W] = CNT_W'(3);
      tick();
    end
  endtask

  task automatic test_freeze();
    bit ok;
    logic [NUM_CH-1:0] exp_s;
    do_reset();
    set_cfg(8, 0, 0, 0, 0, 0, 0, 0);
    en = 1'b1;
    bring_up("freeze", ok);
    for (int idx = 0; idx < 32 && ok; idx++) begin
      exp_s = {2'b00, (idx == 25 || idx == 29), (idx == 8 || idx == 21 || idx == 29)};
      checks++;
      if (strobe !== exp_s) begin
        failures++;
        $display("FAIL freeze idx=%0d: got %b required %b", idx, strobe, exp_s);
      end
      en = !(idx >= 10 && idx < 15);
      if (idx == 20) div[CNT_W +: CNT_W] = CNT_W'(4);
      tick();
    end
  endtask

  task automatic test_lock_glitch();
    int n = 0;
    do_reset();
    pll_locked = 1'b1;
    repeat (8) tick();
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    while (ready !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (n != RUN_LAT) begin
      failures++;
      $display("FAIL lock_glitch: RUN %0d cycles after relock, required %0d", n, RUN_LAT);
    end
    checks++;
    if (loss_cnt !== 8'd0) begin
      failures++;
      $display("FAIL glitch_loss: lock_loss_cnt=%0d required 0", loss_cnt);
    end
  endtask

  task automatic test_saturate();
    bit ok;
    int want;
    do_reset();
    bring_up("saturate", ok);
    for (int k = 1; k <= 300 && ok; k++) begin
      pll_locked = 1'b0;
      repeat (2) tick();
      checks++;
      if (ready !== 1'b1) begin
        failures++;
        $display("FAIL drop_early k=%0d: ready=%b required 1", k, ready);
      end
      tick();
      want = (k > 255) ? 255 : k;
      checks++;
      if (ready !== 1'b0 || rst_sync_n !== 1'b0 || loss_cnt !== 8'(want)) begin
        failures++;
        $display("FAIL drop k=%0d: ready=%b rst_sync_n=%b loss=%0d required 0/0/%0d",
                 k, ready, rst_sync_n, loss_cnt, want);
      end
      bring_up("saturate", ok);
    end
  endtask

`ifdef CLK_STROBE_PHASE_EN
  task automatic test_phase();
    bit ok;
    int want[NUM_CH] = '{3, 8, 1, 6};
    do_reset();
    set_cfg(8, 8, 4, 6, 5, 9, 3, 0);
    en = 1'b1;
    bring_up("phase", ok);
    if (ok) begin
      run_and_check("phase", 30, 100);
      for (int c = 0; c < NUM_CH; c++) begin
        checks++;
        if (first_idx[c] != want[c]) begin
          failures++;
          $display("FAIL phase_first ch%0d: first strobe idx %0d required %0d", c, first_idx[c], want[c]);
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_lock_seq();
    test_divider_rates();
    test_random();
    test_div_change();
    test_freeze();
    test_lock_glitch();
    test_saturate();
`ifdef CLK_STROBE_PHASE_EN
    test_phase();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/clk_strobe_gen.md
# clk_strobe_gen

Parametrised successor to the team's fixed-ratio clock generation. It runs entirely in the single PLL-derived base clock domain. From that one clock it produces NUM_CH runtime-programmable clock-enable strobes (for example the 25 MHz pixel and 12.5 MHz sprite rates from 100 MHz) instead of extra PLL outputs. It also synchronises the PLL lock flag, holds downstream logic in reset until lock has been stable, and counts lock-loss events.

## Interface
- NUM_CH, 4, number of strobe channels
- CNT_W, 8, divider/phase width per channel
- SETTLE_CYC, 16, cycles of continuous synced lock required before RUN (≥1)
- SYNC_STAGES, 2, lock synchroniser depth (≥2)
- clk  in  1  base clock; all logic is on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- pll_locked_i  in  1  asynchronous PLL lock flag
- en_i  in  1  global count enable
- div_i  in  NUM_CH*CNT_W  per-channel divisor; channel c occupies bits [c*CNT_W +: CNT_W]
- phase_i  in  NUM_CH*CNT_W  per-channel start phase; present only with the macro
- strobe_o  out  NUM_CH  one-cycle enable pulses
- ready_o  out  1  high in RUN
- rst_sync_n_o  out  1  synchronous active-low reset for downstream logic
- lock_loss_cnt_o  out  8  saturating count of lock drops while in RUN

## Operation
- FSM states: WAIT_LOCK (state after reset), SETTLE, RUN.
  - WAIT_LOCK → SETTLE when synced lock = 1.
  - SETTLE increments the settle counter each cycle. It returns to WAIT_LOCK immediately if synced lock = 0. It goes to RUN when the counter reaches SETTLE_CYC-1.
  - RUN → WAIT_LOCK when synced lock = 0. On the same edge lock_loss_cnt_o increments, saturating at 255.
- Outside RUN:
  - strobe_o = 0, ready_o = 0, rst_sync_n_o = 0.
  - Channel counters and the settle counter are held at 0.
- On the WAIT_LOCK/SETTLE→RUN edge, each channel loads cnt with its start phase and latches div_eff = div_i.
- In RUN with en_i = 1, per channel:
  - If cnt == div_eff-1: cnt ← 0, strobe asserted, div_eff ← current div_i. Divisor changes therefore apply only at a wrap.
  - Otherwise: cnt ← cnt+1.
- en_i = 0 in RUN freezes all counters and forces strobe_o = 0. No strobe is lost or duplicated; counting resumes from the frozen value.
- div_eff = 0 disables the channel: strobe stays 0 and cnt stays 0. A channel with div_eff = 0 re-latches div_i every cycle.
- div_eff = 1 asserts the strobe on every enabled cycle.
- A start phase ≥ div_eff loads 0.
- lock_loss_cnt_o is cleared only by rst_n.

## Timing
- Reset values: strobe_o = 0, ready_o = 0, rst_sync_n_o = 0, lock_loss_cnt_o = 0, FSM = WAIT_LOCK.
- Lock synchroniser latency is SYNC_STAGES cycles.
- RUN is entered SYNC_STAGES+SETTLE_CYC cycles after pll_locked_i rises, provided it stays high.
- strobe_o is registered: it is high in cycle k+1 when cnt == div_eff-1 with en_i = 1 in cycle k.
- First strobe after RUN entry, for divisor D and phase P: RUN-cycle index D-P, where the entry cycle is index 0 and cnt = P in that cycle.
- ready_o and rst_sync_n_o rise in the first RUN cycle. They fall in the cycle after synced lock falls.
- rst_n asserted mid-operation clears everything asynchronously.

## Configuration
- CLK_STROBE_PHASE_EN defined: phase_i exists and the start phase is phase_i.
- CLK_STROBE_PHASE_EN undefined: the phase_i port is absent and every start phase is 0.

## Structure
- Package clk_strobe_pkg holds the FSM state enum (WAIT_LOCK/SETTLE/RUN) and the lock-loss counter width constant (8).
- Sub-module clk_strobe_ch: one channel's counter, div_eff latch and strobe register. It is instantiated NUM_CH times via generate.
- The top level holds the synchroniser, the FSM, the settle counter and the lock-loss counter.

## Test plan
- **Lock sequencing:** with defaults, raise pll_locked_i at cycle 10 → ready_o and rst_sync_n_o rise at cycle 28 (10+2+16).
- **Divider rates:** divisors {1,2,4,8} with en_i = 1 → strobe periods of 1, 2, 4 and 8 cycles, with the first strobes at RUN indices 1, 2, 4 and 8.
- **Lock glitch:** drop lock for 1 cycle during SETTLE → FSM returns to WAIT_LOCK, RUN is delayed by a full settle, and lock_loss_cnt_o stays 0. Drop lock in RUN 300 times → lock_loss_cnt_o saturates at 255.
- **Divisor change at wrap:** change channel 0 divisor 8 → 3 mid-period → the current period still completes at 8 cycles, and the following periods are 3 cycles.
- **Enable freeze and disabled channel:**
  - en_i low for 5 cycles mid-period → strobe_o stays 0 and the strobe is delayed by exactly 5 cycles.
  - div = 0 → channel stays silent.
- **Phase offset (with CLK_STROBE_PHASE_EN):**
  - D = 8, P = 5 → first strobe at RUN index 3.
  - P = 9 → behaves as P = 0.
